// File: rtl/div_clk_mode_detect.sv
// rtl/div_clk_mode_detect.sv - measures the divider output period and decodes the active divide mode
module div_clk_mode_detect #(
    parameter int DIV0     = 2,
    parameter int DIV1     = 4,
    parameter int DIV2     = 8,
    parameter int DIV3     = 16,
    parameter int LOCK_CNT = 2,
    parameter int TIMEOUT  = 32,
    parameter int CNT_W    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       div_in,
    output logic [1:0] mode_out,
    output logic       valid,
    output logic       mode_chg,
    output logic       err
);

    localparam int MATCH_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t             state;
    logic               div_q;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         cand;
    logic [MATCH_W-1:0] match;

    logic               rise;
    logic               timeout;
    logic [CNT_W-1:0]   period;
    logic               code_ok;
    logic [1:0]         code;
    logic [MATCH_W-1:0] track_match;

    assign rise    = div_in & ~div_q;
    assign period  = cnt + 1'b1;
    assign timeout = (cnt == CNT_W'(TIMEOUT - 1)) && !rise;

    // Map the measured period onto a mode code; anything off-grid is invalid
    always_comb begin
        code_ok = 1'b1;
        code    = 2'd0;
        if (period == CNT_W'(DIV0))      code = 2'd0;
        else if (period == CNT_W'(DIV1)) code = 2'd1;
        else if (period == CNT_W'(DIV2)) code = 2'd2;
        else if (period == CNT_W'(DIV3)) code = 2'd3;
        else                             code_ok = 1'b0;
    end

    // Run length of identical classifications, restarting at 1 on a new code
    always_comb begin
        track_match = MATCH_W'(1);
        if (code == cand) track_match = match + MATCH_W'(1);
    end

    // Rising-edge detector and saturating period counter
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= 1'b0;
            cnt   <= '0;
        end else begin
            div_q <= div_in;
            if (rise)                            cnt <= '0;
            else if (cnt != CNT_W'(TIMEOUT))     cnt <= cnt + 1'b1;
        end
    end

    // Acquire / track / lock state machine with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ACQ;
            cand     <= 2'd0;
            match    <= '0;
            mode_out <= 2'd0;
            valid    <= 1'b0;
            mode_chg <= 1'b0;
            err      <= 1'b0;
        end else begin
            mode_chg <= 1'b0;
            err      <= 1'b0;
            case (state)
                ACQ: begin
                    if (rise) begin
                        state <= TRACK;
                        match <= '0;
                    end
                end
                TRACK: begin
                    if (rise) begin
                        if (!code_ok) begin
                            match <= '0;
                            err   <= 1'b1;
                        end else begin
                            cand  <= code;
                            match <= track_match;
                            if (track_match == MATCH_W'(LOCK_CNT)) begin
                                state    <= LOCK;
                                mode_out <= code;
                                valid    <= 1'b1;
                                mode_chg <= 1'b1;
                            end
                        end
                    end else if (timeout) begin
                        valid <= 1'b0;
                        err   <= 1'b1;
                        match <= '0;
                        state <= ACQ;
                    end
                end
                LOCK: begin
                    if (rise) begin
                        if (!code_ok) begin
                            valid <= 1'b0;
                            match <= '0;
                            err   <= 1'b1;
                            state <= TRACK;
                        end else if (code != mode_out) begin
                            valid <= 1'b0;
                            cand  <= code;
                            match <= MATCH_W'(1);
                            state <= TRACK;
                        end
                    end else if (timeout) begin
                        valid <= 1'b0;
                        err   <= 1'b1;
                        match <= '0;
                        state <= ACQ;
                    end
                end
                default: state <= ACQ;
            endcase
        end
    end

endmodule
